// File: rtl/event_block_packetizer_pkg.sv
// Shared encodings for the event block packetizer: FSM states, FIFO word types
// and the layout of the STATUS word.
package event_block_packetizer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HEADER   = 3'd1;
    localparam logic [2:0] ST_LENGTH   = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_STATUS   = 3'd4;
    localparam logic [2:0] ST_CHECKSUM = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [1:0] END_OF_BLOCK = 2'b11;

    localparam int STATUS_EARLY_BIT = 15;
    localparam int STATUS_CLAMP_BIT = 14;

    function automatic logic [15:0] status_word(input logic early_end, input logic clamped);
        logic [15:0] w;
        w = '0;
        w[STATUS_EARLY_BIT] = early_end;
        w[STATUS_CLAMP_BIT] = clamped;
        return w;
    endfunction

endpackage

// File: rtl/event_block_checksum.sv
// 16-bit XOR accumulator over the payload words of one block.
module event_block_checksum (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] din_i,
    output logic [15:0] sum_o
);

    logic [15:0] r_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_sum <= '0;
        end else if (en_i) begin
            r_sum <= r_sum ^ din_i;
        end
    end

    assign sum_o = r_sum;

endmodule

// File: rtl/event_block_packetizer.sv
// Wraps one event block from the muxed FIFO into a packet:
// header, length, payload, status, checksum.
module event_block_packetizer
    import event_block_packetizer_pkg::*;
#(
    parameter int          MAX_WORDS = 4096,
    parameter logic [7:0]  SYNC_BYTE = 8'hEB
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fifo_empty_i,
    input  logic [15:0] fifo_dat_i,
    input  logic [1:0]  fifo_type_i,
    input  logic [15:0] fifo_nwords_i,
    output logic        fifo_rd_o,
    output logic        fifo_block_done_o,
    output logic [15:0] dout_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic        busy_o,
    output logic [2:0]  dbg_state_o
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [7:0]  r_seq;
    logic [15:0] r_count;
    logic [15:0] r_len;
    logic        r_clamped;
    logic        r_early_end;

    logic        w_valid;
    logic [15:0] w_dout;
    logic        w_xfer;
    logic        w_rd;
    logic        w_start;
    logic        w_eob;
    logic        w_last_word;
    logic [15:0] w_count_next;
    logic [15:0] w_sum;

    // Output word and valid per state. A word moves when dout_valid_o and
    // dout_ready_i are both high; once valid is raised the word is held until
    // it moves (in DATA the FIFO head holds it, since it only pops on a move).
    always_comb begin
        w_valid = 1'b0;
        w_dout  = '0;
        case (r_state)
            ST_HEADER: begin
                w_valid = 1'b1;
                w_dout  = {SYNC_BYTE, r_seq};
            end
            ST_LENGTH: begin
                w_valid = 1'b1;
                w_dout  = r_len;
            end
            ST_DATA: begin
                w_valid = !fifo_empty_i;
                w_dout  = fifo_dat_i;
            end
            ST_STATUS: begin
                w_valid = 1'b1;
                w_dout  = status_word(r_early_end, r_clamped);
            end
            ST_CHECKSUM: begin
                w_valid = 1'b1;
                w_dout  = w_sum;
            end
            default: begin
                w_valid = 1'b0;
                w_dout  = '0;
            end
        endcase
        if (rst_i) begin
            w_valid = 1'b0;
            w_dout  = '0;
        end
    end

    assign w_xfer       = w_valid && dout_ready_i;
    assign w_rd         = (r_state == ST_DATA) && w_xfer;
    assign w_start      = (r_state == ST_IDLE) && !fifo_empty_i;
    assign w_eob        = (fifo_type_i == END_OF_BLOCK);
    assign w_count_next = r_count + 16'd1;
    assign w_last_word  = (w_count_next == r_len) || w_eob;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_seq       <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_clamped   <= 1'b0;
            r_early_end <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_len       <= (fifo_nwords_i > MAX_LEN) ? MAX_LEN : fifo_nwords_i;
                        r_clamped   <= (fifo_nwords_i > MAX_LEN);
                        r_count     <= '0;
                        r_early_end <= 1'b0;
                        r_state     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (w_xfer) r_state <= ST_LENGTH;
                end
                ST_LENGTH: begin
                    if (w_xfer) r_state <= (r_len == 16'd0) ? ST_STATUS : ST_DATA;
                end
                ST_DATA: begin
                    if (w_rd) begin
                        r_count <= w_count_next;
                        if (w_last_word) begin
                            r_early_end <= w_eob && (w_count_next < r_len);
                            r_state     <= ST_STATUS;
                        end
                    end
                end
                ST_STATUS: begin
                    if (w_xfer) r_state <= ST_CHECKSUM;
                end
                ST_CHECKSUM: begin
                    if (w_xfer) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_seq   <= r_seq + 8'd1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    event_block_checksum u_checksum (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_start),
        .en_i  (w_rd),
        .din_i (fifo_dat_i),
        .sum_o (w_sum)
    );

    assign dout_o            = w_dout;
    assign dout_valid_o      = w_valid;
    assign fifo_rd_o         = w_rd;
    assign fifo_block_done_o = (r_state == ST_DONE) && !rst_i;
    assign busy_o            = (r_state != ST_IDLE) && !rst_i;
    assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_event_block_packetizer.sv
// Bench for event_block_packetizer: FIFO/sink driver, packet-level model with
// an expected-word queue, per-cycle output compare and a final report.
module tb_event_block_packetizer;
    import event_block_packetizer_pkg::*;

    localparam int MAXW = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty_i;
    logic [15:0] fifo_dat_i;
    logic [1:0]  fifo_type_i;
    logic [15:0] fifo_nwords_i;
    logic        fifo_rd_o;
    logic        fifo_block_done_o;
    logic [15:0] dout_o;
    logic        dout_valid_o;
    logic        dout_ready_i;
    logic        busy_o;
    logic [2:0]  dbg_state_o;

    event_block_packetizer #(.MAX_WORDS(MAXW), .SYNC_BYTE(8'hEB)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .fifo_empty_i      (fifo_empty_i),
        .fifo_dat_i        (fifo_dat_i),
        .fifo_type_i       (fifo_type_i),
        .fifo_nwords_i     (fifo_nwords_i),
        .fifo_rd_o         (fifo_rd_o),
        .fifo_block_done_o (fifo_block_done_o),
        .dout_o            (dout_o),
        .dout_valid_o      (dout_valid_o),
        .dout_ready_i      (dout_ready_i),
        .busy_o            (busy_o),
        .dbg_state_o       (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];     // {is_payload, word}
    logic [17:0] blk_q[$];     // {type, data} of the block being built
    logic [17:0] fifo_q[$];
    int          gap_q[$];

    bit          fifo_en  = 1'b0;
    bit          rand_rdy = 1'b0;
    int          gap_max  = 0;
    int          reads_seen = 0;
    int          popped     = 0;
    int          done_seen  = 0;
    int          done_base  = 0;
    int          reads_base = 0;
    bit          expect_done = 1'b0;
    logic [7:0]  exp_seq = 8'd0;
    int          exp_ndata  = 0;
    int          exp_remain = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- driver: FIFO source and sink ready ----------------
    initial begin
        fifo_empty_i = 1'b1;
        fifo_dat_i   = '0;
        fifo_type_i  = '0;
        dout_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            while (popped < reads_seen) begin
                if (fifo_q.size() > 0) begin
                    fifo_q.delete(0);
                    gap_q.delete(0);
                end
                popped++;
            end
            fifo_empty_i = 1'b1;
            if (fifo_en && done_seen == done_base && fifo_q.size() > 0) begin
                if (gap_q[0] > 0) gap_q[0] = gap_q[0] - 1;
                else fifo_empty_i = 1'b0;
            end
            if (fifo_q.size() > 0) {fifo_type_i, fifo_dat_i} = fifo_q[0];
            dout_ready_i = rand_rdy ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic        prev_hold;
        logic [15:0] prev_dout;
        logic [16:0] w;
        prev_hold = 1'b0;
        prev_dout = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_rd",    32'(fifo_rd_o), 0);
                check("rst_done",  32'(fifo_block_done_o), 0);
                check("rst_valid", 32'(dout_valid_o), 0);
                check("rst_busy",  32'(busy_o), 0);
                check("rst_dout",  32'(dout_o), 0);
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(dout_valid_o), 1);
                    check("hold_dout",  32'(dout_o), 32'(prev_dout));
                end
                if (fifo_rd_o) begin
                    reads_seen++;
                    check("rd_while_empty", 32'(fifo_empty_i), 0);
                    check("rd_without_xfer", 32'(dout_valid_o && dout_ready_i), 1);
                end
                if (dout_valid_o && dout_ready_i) begin
                    check("word_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        check("word", 32'(dout_o), 32'(w[15:0]));
                        check("word_is_read", 32'(fifo_rd_o), 32'(w[16]));
                    end
                end
                if (dout_valid_o) check("valid_busy", 32'(busy_o), 1);
                if (fifo_block_done_o) begin
                    done_seen++;
                    check("done_expected", 32'(expect_done), 1);
                    check("done_after_packet", 32'(exp_q.size()), 0);
                    check("done_busy", 32'(busy_o), 1);
                end
                prev_hold = dout_valid_o && !dout_ready_i;
                prev_dout = dout_o;
            end
        end
    end

    // ---------------- packet model ----------------
    task automatic build_packet(input int n);
        int         len;
        bit         clamped;
        bit         early;
        logic [15:0] cs;
        int         nd;
        len     = (n > MAXW) ? MAXW : n;
        clamped = (n > MAXW);
        early   = 1'b0;
        cs      = '0;
        nd      = 0;
        exp_q.push_back({1'b0, 8'hEB, exp_seq});
        exp_q.push_back({1'b0, 16'(len)});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b1, blk_q[i][15:0]});
            cs = cs ^ blk_q[i][15:0];
            nd++;
            if (blk_q[i][17:16] == 2'b11) begin
                early = (i + 1 < len);
                break;
            end
        end
        exp_q.push_back({1'b0, early, clamped, 14'b0});
        exp_q.push_back({1'b0, cs});
        exp_ndata  = nd;
        exp_remain = blk_q.size() - nd;
        exp_seq    = exp_seq + 8'd1;
    endtask

    task automatic start_block(input int n);
        build_packet(n);
        reads_base = reads_seen;
        done_base  = done_seen;
        foreach (blk_q[i]) begin
            fifo_q.push_back(blk_q[i]);
            gap_q.push_back((gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
        end
        fifo_nwords_i = 16'(n);
        expect_done   = 1'b1;
        fifo_en       = 1'b1;
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic finish_block(input string name);
        int cyc;
        cyc = 0;
        while (done_seen == done_base && cyc < 20000) begin
            step();
            cyc++;
        end
        if (done_seen == done_base) begin
            check({name, "_done_timeout"}, 32'(done_seen - done_base), 1);
            finish_up();
        end
        @(negedge clk);
        check({name, "_reads"},  32'(reads_seen - reads_base), 32'(exp_ndata));
        check({name, "_remain"}, 32'(fifo_q.size()), 32'(exp_remain));
        check({name, "_idle"},   32'(busy_o), 0);
        check({name, "_pulses"}, 32'(done_seen - done_base), 1);
        step();
        expect_done = 1'b0;
        fifo_en     = 1'b0;
        fifo_q.delete();
        gap_q.delete();
        blk_q.delete();
    endtask

    task automatic do_reset();
        step();
        rst         = 1'b1;
        fifo_en     = 1'b0;
        expect_done = 1'b0;
        exp_q.delete();
        step();
        step();
        @(negedge clk);
        check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
        step();
        fifo_q.delete();
        gap_q.delete();
        blk_q.delete();
        exp_seq = 8'd0;
        rst     = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int nw;
        int pos;
        int d_before;
        int cyc;
        rst           = 1'b1;
        fifo_nwords_i = '0;
        do_reset();

        // three-word block, payload 1/2/4
        for (int i = 0; i < 3; i++) blk_q.push_back({2'b00, 16'(1 << i)});
        start_block(3);
        check("m3_hdr", 32'(exp_q[0][15:0]), 32'h0000_EB00);
        check("m3_len", 32'(exp_q[1][15:0]), 32'h0003);
        check("m3_d0",  32'(exp_q[2][15:0]), 32'h0001);
        check("m3_d1",  32'(exp_q[3][15:0]), 32'h0002);
        check("m3_d2",  32'(exp_q[4][15:0]), 32'h0004);
        check("m3_sts", 32'(exp_q[5][15:0]), 32'h0000);
        check("m3_cs",  32'(exp_q[6][15:0]), 32'h0007);
        finish_block("n3");
        do_reset();

        // zero-length block: no reads, word stays queued
        blk_q.push_back({2'b00, 16'hABCD});
        start_block(0);
        check("m0_size", 32'(exp_q.size()), 4);
        check("m0_hdr",  32'(exp_q[0][15:0]), 32'h0000_EB00);
        check("m0_cs",   32'(exp_q[3][15:0]), 32'h0000);
        finish_block("n0");
        do_reset();

        // early end on second word
        for (int i = 0; i < 5; i++)
            blk_q.push_back({(i == 1) ? 2'b11 : 2'b00, 16'($urandom)});
        start_block(5);
        check("me_len", 32'(exp_q[1][15:0]), 32'h0005);
        check("me_sts", 32'(exp_q[4][15:0]), 32'h8000);
        finish_block("early");
        do_reset();

        // oversize request clamped to MAX_WORDS
        for (int i = 0; i < MAXW + 4; i++) blk_q.push_back({2'b00, 16'($urandom)});
        start_block(5000);
        check("mc_len", 32'(exp_q[1][15:0]), 32'h1000);
        check("mc_sts", 32'(exp_q[2 + MAXW][15:0]), 32'h4000);
        finish_block("clamp");
        do_reset();

        // random ready, FIFO gaps, seq wrap
        rand_rdy = 1'b1;
        gap_max  = 3;
        for (int k = 0; k < 257; k++) begin
            n  = $urandom_range(0, 6);
            nw = n + $urandom_range(0, 2);
            if (nw == 0) nw = 1;
            pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
            for (int i = 0; i < nw; i++)
                blk_q.push_back({(i == pos) ? 2'b11 : 2'($urandom_range(0, 2)), 16'($urandom)});
            start_block(n);
            if (k == 255) check("seq_ff_hdr", 32'(exp_q[0][15:0]), 32'h0000_EBFF);
            if (k == 256) check("seq_wrap_hdr", 32'(exp_q[0][15:0]), 32'h0000_EB00);
            finish_block("rand");
        end

        // reset in the middle of DATA
        rand_rdy = 1'b0;
        gap_max  = 0;
        for (int i = 0; i < 8; i++) blk_q.push_back({2'b00, 16'($urandom)});
        start_block(8);
        cyc = 0;
        while (reads_seen - reads_base < 3 && cyc < 200) begin
            step();
            cyc++;
        end
        check("mid_reads_reached", 32'(reads_seen - reads_base >= 3), 1);
        d_before = done_seen;
        do_reset();
        repeat (3) step();
        check("no_done_after_reset", 32'(done_seen), 32'(d_before));
        blk_q.push_back({2'b00, 16'h1234});
        blk_q.push_back({2'b00, 16'h00FF});
        start_block(2);
        check("post_rst_hdr", 32'(exp_q[0][15:0]), 32'h0000_EB00);
        check("post_rst_cs",  32'(exp_q[5][15:0]), 32'h0000_12CB);
        finish_block("post_rst");

        finish_up();
    end

endmodule

// File: doc/event_block_packetizer.md
EVENT_BLOCK_PACKETIZER -- requirements
Module: event_block_packetizer

Interface
REQ-001 Parameter MAX_WORDS, default 4096, SHALL be the largest block payload in 16-bit words; larger requests are clamped.
REQ-002 Parameter SYNC_BYTE, default 8'hEB, SHALL be the upper byte of every header word.
REQ-003 clk_i  in  1  SHALL be the single clock; it is the muxed FIFO clock. All logic SHALL be rising-edge on clk_i.
REQ-004 rst_i  in  1  SHALL be a synchronous, active-high reset.
REQ-005 fifo_empty_i  in  1  SHALL be the muxed event FIFO empty flag (first-word-fall-through).
REQ-006 fifo_dat_i  in  16  SHALL be the muxed FIFO data, valid while fifo_empty_i=0.
REQ-007 fifo_type_i  in  2  SHALL be the word type; 2'b11 marks the last word of a block.
REQ-008 fifo_nwords_i  in  16  SHALL be the muxed block length in words, sampled at block start.
REQ-009 fifo_rd_o  out  1  SHALL pop one FIFO word per high cycle.
REQ-010 fifo_block_done_o  out  1  SHALL be a one-cycle pulse at block completion.
REQ-011 dout_o  out  16  SHALL carry the output packet word.
REQ-012 dout_valid_o  out  1 / dout_ready_i  in  1  SHALL form a valid/ready handshake; a word transfers when both are high.
REQ-013 busy_o  out  1  SHALL be high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, HEADER, LENGTH, DATA, STATUS, CHECKSUM, DONE.
REQ-015 IDLE -> HEADER SHALL occur on the first cycle with fifo_empty_i=0. That cycle SHALL latch len = min(fifo_nwords_i, MAX_WORDS) and the clamp flag, and clear the word counter and checksum.
REQ-016 HEADER SHALL emit {SYNC_BYTE, seq[7:0]}. LENGTH SHALL emit len.
REQ-017 In DATA, dout_o SHALL equal fifo_dat_i and dout_valid_o SHALL equal !fifo_empty_i. fifo_rd_o SHALL equal dout_valid_o && dout_ready_i, combinationally, with zero added latency.
REQ-018 Each DATA transfer SHALL increment the 16-bit word counter and XOR the word into a 16-bit checksum.
REQ-019 DATA -> STATUS SHALL occur after the transfer that makes count==len, or on a transfer with fifo_type_i==2'b11, whichever is first.
REQ-020 The early_end flag SHALL be set when the exit is caused by type 2'b11 with count+1 < len.
REQ-021 len==0 SHALL go LENGTH -> STATUS directly, with no FIFO read.
REQ-022 fifo_empty_i=1 during DATA SHALL stall with dout_valid_o=0 and fifo_rd_o=0, without timeout.
REQ-023 STATUS SHALL emit {early_end, clamped, 14'b0}. CHECKSUM SHALL emit the checksum.
REQ-024 In HEADER, LENGTH, STATUS and CHECKSUM, dout_valid_o SHALL be 1, and the state SHALL advance only on a transfer.
REQ-025 DONE SHALL assert fifo_block_done_o for exactly one cycle, increment seq (8-bit, wrapping 255->0), and return to IDLE.
REQ-026 fifo_rd_o SHALL never be high outside DATA and SHALL never be high while fifo_empty_i=1.
REQ-027 dout_o and dout_valid_o SHALL hold stable while dout_valid_o=1 and dout_ready_i=0. The DATA-state exception: data may change only through the FIFO, which does not pop without a read.

Reset
REQ-028 While rst_i=1, the state SHALL be IDLE and seq, count, len, checksum and flags SHALL be 0.
REQ-029 While rst_i=1, fifo_rd_o, fifo_block_done_o, dout_valid_o and busy_o SHALL be 0, and dout_o SHALL be 16'h0000.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no block_done pulse; unread FIFO words remain for the upstream reset.

Structure
REQ-031 The shared package SHALL hold the state encoding, the type code END_OF_BLOCK=2'b11, and the STATUS bit positions (bit15 early_end, bit14 clamped).
REQ-032 One sub-module SHALL be used: event_block_checksum (16-bit XOR accumulator with clear and enable).
REQ-033 The implementation SHALL be a single always block for registers plus combinational output decode.

Verification
REQ-034 nwords=3, data 0x0001/0x0002/0x0004, ready=1 -> output 0xEB00, 0x0003, 0x0001, 0x0002, 0x0004, 0x0000, 0x0007; one block_done pulse; 3 reads.
REQ-035 nwords=0 -> output 0xEB00, 0x0000, 0x0000, 0x0000; no reads; block_done pulses once.
REQ-036 nwords=5 with type 2'b11 on the 2nd word -> 2 data words; STATUS=0x8000; 3 words remain in the FIFO.
REQ-037 nwords=5000 -> LENGTH=0x1000 (4096); STATUS=0x4000; exactly 4096 reads.
REQ-038 Random dout_ready_i toggling plus FIFO empty gaps -> identical packet content; no read while empty; output stable while stalled; 256 blocks show seq wrapping to 0x00.
REQ-039 rst_i pulsed mid-DATA -> outputs 0 the next cycle; no block_done; the next block starts with header 0xEB00.
